// File: rtl/i4674_serial_monitor.sv
// Serial pattern monitor: shifts N into a history register and flags when it matches PATTERN.
// Optional macro I4674_STICKY_EN turns the match pulse into a flag held until reset.
module i4674_serial_monitor #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011
) (
  input  logic CK,
  input  logic reset,
  input  logic N,
  output logic output_single
);

  localparam int FILL_W = $clog2(PATTERN_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_W);

  generate
    if (PATTERN_W < 2 || PATTERN_W > 16) begin : g_bad_width
      $error("i4674_serial_monitor: PATTERN_W must be in 2..16");
    end
  endgenerate

  logic [PATTERN_W-1:0] hist;
  logic [FILL_W-1:0]    fill;
  logic [PATTERN_W-1:0] next_hist;
  logic [FILL_W-1:0]    next_fill;
  logic                 match;

  // Fill guard keeps a zero-filled history from matching before enough real samples arrive.
  always_comb begin
    next_hist = {hist[PATTERN_W-2:0], N};
    next_fill = (fill == FILL_MAX) ? fill : fill + 1'b1;
    match     = (next_hist == PATTERN) && (next_fill == FILL_MAX);
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      hist          <= '0;
      fill          <= '0;
      output_single <= 1'b0;
    end else begin
      hist <= next_hist;
      fill <= next_fill;
`ifdef I4674_STICKY_EN
      output_single <= output_single | match;
`else
      output_single <= match;
`endif
    end
  end

endmodule

// File: tb/tb_i4674_serial_monitor.sv
// Directed bench for i4674_serial_monitor: pattern 1011 instance plus an all-zeros pattern instance.
// Expectations follow the sticky behaviour when I4674_STICKY_EN is defined.
module tb_i4674_serial_monitor;

`ifdef I4674_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic CK;
  logic reset;
  logic n_a;
  logic n_z;
  logic out_a;
  logic out_z;

  int total_checks;
  int passed_checks;

  i4674_serial_monitor #(.PATTERN_W(4), .PATTERN(4'b1011)) dut_a (
    .CK(CK), .reset(reset), .N(n_a), .output_single(out_a)
  );

  i4674_serial_monitor #(.PATTERN_W(4), .PATTERN(4'b0000)) dut_z (
    .CK(CK), .reset(reset), .N(n_z), .output_single(out_z)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  typedef struct {
    logic do_rst;
    logic n;
    logic exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic n, logic e);
    vec_t v;
    v.do_rst = r;
    v.n      = n;
    v.exp    = e;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  initial begin
    logic flag_a;
    logic flag_z;
    logic exp_eff;

    total_checks  = 0;
    passed_checks = 0;
    flag_a = 1'b0;
    flag_z = 1'b0;

    // idle, then single match with trailing 0
    add(0, 0, 0); add(0, 1, 0);
    add(1, 1, 0); add(0, 0, 0); add(0, 1, 0); add(0, 1, 1); add(0, 0, 0);
    // overlap 1011011
    add(1, 1, 0); add(0, 0, 0); add(0, 1, 0); add(0, 1, 1);
    add(0, 0, 0); add(0, 1, 0); add(0, 1, 1);
    // mid-stream reset: 1,0,1 | reset | 1,0,1,1,0
    add(1, 1, 0); add(0, 0, 0); add(0, 1, 0);
    add(1, 1, 0); add(0, 0, 0); add(0, 1, 0); add(0, 1, 1); add(0, 0, 0);

    reset = 1'b0;
    n_a   = 1'b0;
    n_z   = 1'b1;
    @(posedge CK);
    #1;
    check("reset_a", out_a, 1'b0);
    check("reset_z", out_z, 1'b0);
    @(negedge CK);
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge CK);
      if (vecs[i].do_rst) begin
        reset = 1'b0;
        #1;
        check("async_rst_a", out_a, 1'b0);
        flag_a = 1'b0;
        #1;
        reset = 1'b1;
      end
      n_a = vecs[i].n;
      @(posedge CK);
      #1;
      exp_eff = STICKY ? (vecs[i].exp | flag_a) : vecs[i].exp;
      flag_a  = exp_eff;
      check($sformatf("vec_a[%0d]", i), out_a, exp_eff);
    end

    // all-zeros pattern: fill guard and back-to-back pulses
    @(negedge CK);
    reset = 1'b0;
    #1;
    check("async_rst_z", out_z, 1'b0);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge CK);
      n_z = 1'b0;
      @(posedge CK);
      #1;
      exp_eff = (k >= 3) ? 1'b1 : 1'b0;
      flag_z  = flag_z | exp_eff;
      check($sformatf("zero_pat[%0d]", k), out_z, exp_eff);
    end
    @(negedge CK);
    n_z = 1'b1;
    @(posedge CK);
    #1;
    check("zero_pat_break", out_z, STICKY ? flag_z : 1'b0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/i4674_serial_monitor.md
Name: i4674_serial_monitor

Overview:
- Single-bit serial pattern monitor from the I4674 benchmark set.
- Samples input N on every rising CK into a history shift register and compares the history against a fixed pattern.
- Produces a registered one-cycle pulse on output_single on each match; overlapping matches are allowed.
- Used as a small sequential leaf cell in the trojan-detection benchmark suite.

Parameters:
- PATTERN_W, 4, pattern length in bits, legal range 2..16.
- PATTERN, 4'b1011, target sequence; the MSB is the oldest sampled bit and the LSB is the newest.

Ports:
- CK  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- N  input  1  serial data bit, sampled on rising CK.
- output_single  output  1  match pulse, registered.

Behaviour:
- Reset (reset = 0, asynchronous, independent of CK):
  - hist (PATTERN_W bits) clears to 0.
  - fill counter clears to 0.
  - output_single clears to 0 immediately.
- Deassertion of reset takes effect on the next rising CK; no synchronizer inside the block.
- Each rising CK while reset = 1:
  - hist <= {hist[PATTERN_W-2:0], N}.
  - fill <= min(fill + 1, PATTERN_W); fill saturates and never wraps.
- Match condition, evaluated on the next-state values: next_hist == PATTERN and next_fill == PATTERN_W.
- output_single <= match, so it is high for exactly the one cycle following the edge that sampled the final pattern bit.
- Latency: the last pattern bit sampled at edge k gives output_single = 1 during the interval from edge k to edge k+1.
- Boundary conditions:
  - Fewer than PATTERN_W bits sampled since reset: no match, even if zero-filled history equals PATTERN (e.g. a pattern of all zeros).
  - Overlap: with PATTERN = 1011, the stream 1011011 yields two pulses, on the 4th and 7th samples.
  - Back-to-back matches (e.g. an all-ones pattern with constant N = 1) keep output_single high on consecutive cycles.
  - Reset asserted mid-stream discards partial history; detection restarts from an empty fill.
- N is assumed synchronous to CK. No X-propagation handling is required beyond reset.
- Structure: fill counter width = clog2(PATTERN_W+1); no combinational path from N to output_single.
- Expected RTL size: about 120–200 lines including the parameter check (an elaboration-time error if PATTERN_W is outside 2..16).

Optional Feature:
- Macro: I4674_STICKY_EN.
- Defined: output_single becomes a sticky flag. It sets on the first match and holds 1 until reset is asserted; subsequent matches have no further effect.
- Undefined (default): one-cycle pulse per match as specified above.

Test Plan:
1. Reset and idle:
   - Hold reset = 0 for 5 ns, then release.
   - Drive N = 0, then N = 1, one CK edge each.
   - Required: output_single = 0 throughout, including while reset is low with CK running.
2. Single match:
   - After reset, drive N = 1,0,1,1 on four edges.
   - Required: output_single = 1 for exactly one cycle after the 4th edge, then 0 when N = 0 follows.
3. Overlap:
   - Drive N = 1,0,1,1,0,1,1.
   - Required: pulses after the 4th and 7th edges only; 0 elsewhere.
4. Fill guard:
   - Build with PATTERN = 4'b0000.
   - Drive N = 0 on each edge after reset.
   - Required: first pulse after the 4th edge, not earlier; output stays 1 on every following edge while N = 0.
5. Mid-stream reset:
   - Drive N = 1,0,1, then pulse reset = 0 between edges, then drive N = 1.
   - Required: output_single drops asynchronously and no pulse follows the 4th bit; 1,0,1,1 after release produces a pulse.
6. Sticky build (I4674_STICKY_EN defined):
   - Drive 1,0,1,1 then 0,0,0.
   - Required: output_single = 1 from the 4th edge onward until reset = 0, after which it reads 0 immediately.
